spi_master_tx: RTL and testbench

Single-byte SPI master transmitter, mode 0 (CPOL=0, CPHA=0), MSB first. It accepts one byte over a valid/ready handshake and drives one complete chip-select frame: CS low, 8 SCK pulses, CS high. This is the FPGA-side initiator that feeds byte-per-frame SPI receivers in the design, which sample MOSI on SCK rising edges and latch the byte on the CS rising edge. An optional MISO capture path returns the byte shifted in during the same frame.

---
 rtl/spi_master_tx_if.sv | 43 ++++
 rtl/spi_master_tx.sv | 174 +++++++++++++++++
 tb/tb_spi_master_tx.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_tx_if.sv
// Bus bundle for the single-byte SPI master transmitter.
// The master modport is the transmitter's own view of the bus.
// The slave modport is the view of whatever drives it and watches the SPI pins.
//
// Handshake: a byte is accepted on a rising clock edge where i_valid and
// o_ready are both high. o_ready is high only while the transmitter is idle.
// i_valid may be raised at any time. A request made while o_ready is low is
// dropped, not queued. i_data is sampled only on the accepting edge.
interface spi_master_tx_if;
    logic [7:0] i_data;
    logic       i_valid;
    logic       o_ready;
    logic       o_sck;
    logic       o_mosi;
    logic       o_cs;
    logic       i_miso;
    logic [7:0] o_rx_data;
    logic       o_done;

    modport master (
        input  i_data,
        input  i_valid,
        input  i_miso,
        output o_ready,
        output o_sck,
        output o_mosi,
        output o_cs,
        output o_rx_data,
        output o_done
    );

    modport slave (
        output i_data,
        output i_valid,
        output i_miso,
        input  o_ready,
        input  o_sck,
        input  o_mosi,
        input  o_cs,
        input  o_rx_data,
        input  o_done
    );
endinterface

// File: rtl/spi_master_tx.sv
// Single-byte SPI master transmitter: mode 0 (CPOL=0, CPHA=0), MSB first.
// Each accepted byte produces one frame: CS low, 8 SCK pulses, CS high.
// Optional feature macro: SPI_MASTER_MISO_EN builds the MISO receive path.
// Without it, o_rx_data is tied to zero and i_miso is ignored.
// The FSM state is exported on o_state for debug and checker binding.
module spi_master_tx #(
    parameter int CLK_DIV = 4,   // SCK half-period in i_clk cycles, >= 1
    parameter int CS_IDLE = 8    // minimum CS-high time between frames, >= 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    spi_master_tx_if.master   bus,
    output logic [2:0]        o_state
);

    localparam int MAX_PHASE = (CLK_DIV > CS_IDLE) ? CLK_DIV : CS_IDLE;
    localparam int CW        = $clog2(MAX_PHASE + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_HIGH  = 3'd2,
        S_LOW   = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    bit_cnt_q;
    logic [7:0]    tx_q;
    logic          cs_q;
    logic          sck_q;
    logic          mosi_q;
    logic          done_q;
    logic [7:0]    rx_data_q;

    logic          phase_end;
    logic          gap_end;
    logic [3:0]    bit_cnt_d;
    logic [7:0]    tx_d;
    logic          enter_high;
    logic          enter_gap;

    // Phase timing and the next value of the shift register and bit count.
    always_comb begin
        phase_end  = (cnt_q == CW'(CLK_DIV - 1));
        gap_end    = (cnt_q == CW'(CS_IDLE - 1));
        bit_cnt_d  = bit_cnt_q + 4'd1;
        tx_d       = {tx_q[6:0], 1'b0};
        enter_high = phase_end &&
                     ((state_q == S_SETUP) ||
                      ((state_q == S_LOW) && (bit_cnt_q < 4'd8)));
        enter_gap  = phase_end && (state_q == S_LOW) && (bit_cnt_q >= 4'd8);
    end

    // Frame FSM. The outputs are loaded on the edge that enters the state they belong to.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= 4'd0;
            tx_q      <= 8'h00;
            cs_q      <= 1'b1;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.i_valid) begin
                        tx_q      <= bus.i_data;
                        bit_cnt_q <= 4'd0;
                        cnt_q     <= '0;
                        cs_q      <= 1'b0;
                        mosi_q    <= bus.i_data[7];
                        state_q   <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (phase_end) begin
                        cnt_q   <= '0;
                        sck_q   <= 1'b1;
                        state_q <= S_HIGH;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_HIGH: begin
                    if (phase_end) begin
                        cnt_q     <= '0;
                        sck_q     <= 1'b0;
                        bit_cnt_q <= bit_cnt_d;
                        // After the 8th rise, MOSI keeps bit 0 through the CS hold phase.
                        if (bit_cnt_d < 4'd8) begin
                            tx_q   <= tx_d;
                            mosi_q <= tx_d[7];
                        end
                        state_q <= S_LOW;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_LOW: begin
                    if (phase_end) begin
                        cnt_q <= '0;
                        if (bit_cnt_q < 4'd8) begin
                            sck_q   <= 1'b1;
                            state_q <= S_HIGH;
                        end else begin
                            cs_q    <= 1'b1;
                            mosi_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_GAP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_GAP: begin
                    if (gap_end) begin
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    cs_q    <= 1'b1;
                    sck_q   <= 1'b0;
                    mosi_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SPI_MASTER_MISO_EN
    logic [7:0] rx_sh_q;

    // Receive path: shift MISO in on every SCK rise, and publish the byte when CS returns high.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_sh_q   <= 8'h00;
            rx_data_q <= 8'h00;
        end else begin
            if (enter_high) begin
                rx_sh_q <= {rx_sh_q[6:0], bus.i_miso};
            end
            if (enter_gap) begin
                rx_data_q <= rx_sh_q;
            end
        end
    end
`else
    logic unused_rx;

    // Without the receive path, the received byte is constant zero.
    always_comb begin
        rx_data_q = 8'h00;
        unused_rx = bus.i_miso ^ enter_high ^ enter_gap;
    end
`endif

    assign bus.o_ready   = (state_q == S_IDLE);
    assign bus.o_cs      = cs_q;
    assign bus.o_sck     = sck_q;
    assign bus.o_mosi    = mosi_q;
    assign bus.o_done    = done_q;
    assign bus.o_rx_data = rx_data_q;
    assign o_state       = state_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Directed bench for spi_master_tx with CLK_DIV=2 and CS_IDLE=8.
// MISO is looped back to MOSI. When SPI_MASTER_MISO_EN is defined, each frame
// must return its own byte. Otherwise o_rx_data must stay zero.
module tb_spi_master_tx;

    localparam int CLK_DIV    = 2;
    localparam int CS_IDLE    = 8;
    localparam int CS_LOW_LEN = 34;   // 17 * CLK_DIV
    localparam int GAP_B2B    = 9;    // CS_IDLE + 1 accept cycle
    localparam int READY_LAG  = 8;    // CS_IDLE

    logic       clk;
    logic       rst;
    logic [2:0] dbg_state;

    spi_master_tx_if bus ();

    spi_master_tx #(
        .CLK_DIV(CLK_DIV),
        .CS_IDLE(CS_IDLE)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .bus    (bus),
        .o_state(dbg_state)
    );

    assign bus.i_miso = bus.o_mosi;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q[$];   // {expected rx byte, expected MOSI byte}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic [7:0] exp_bits;
        logic [7:0] exp_rx;
    } vec_t;

    function automatic logic [7:0] rx_expect(input logic [7:0] loop_byte);
`ifdef SPI_MASTER_MISO_EN
        return loop_byte;
`else
        return 8'h00 & loop_byte;
`endif
    endfunction

    task automatic push_exp(input logic [7:0] bits, input logic [7:0] rx);
        exp_q.push_back({rx_expect(rx), bits});
    endtask

    // ---------------- monitor ----------------
    int         done_cnt = 0;
    int         rise_cnt = 0;
    int         cs_low_cnt = 0;
    int         cs_high_cnt = 0;
    int         last_gap = 0;
    int         mosi_glitch = 0;
    logic [7:0] sh = 8'h00;
    logic       prev_sck = 1'b0;
    logic       prev_cs = 1'b1;
    logic       prev_mosi = 1'b0;

    always @(negedge clk) begin
        logic [15:0] e;
        if (rst) begin
            rise_cnt    = 0;
            cs_low_cnt  = 0;
            cs_high_cnt = 0;
            mosi_glitch = 0;
            sh          = 8'h00;
        end else begin
            if (!bus.o_cs) begin
                cs_low_cnt++;
                if (prev_cs) begin
                    last_gap    = cs_high_cnt;
                    cs_high_cnt = 0;
                end else if (bus.o_mosi !== prev_mosi && !(prev_sck && !bus.o_sck)) begin
                    mosi_glitch++;
                end
            end else begin
                cs_high_cnt++;
            end
            if (bus.o_sck && !prev_sck) begin
                sh = {sh[6:0], bus.o_mosi};
                rise_cnt++;
            end
            if (bus.o_done) begin
                done_cnt++;
                cs_high_cnt = 1;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("mosi_bits", {24'd0, sh}, {24'd0, e[7:0]});
                    check("sck_rises", rise_cnt, 8);
                    check("cs_low_len", cs_low_cnt, CS_LOW_LEN);
                    check("rx_at_done", {24'd0, bus.o_rx_data}, {24'd0, e[15:8]});
                    check("mosi_stable", mosi_glitch, 0);
                end
                rise_cnt    = 0;
                cs_low_cnt  = 0;
                mosi_glitch = 0;
            end
        end
        prev_sck  = bus.o_sck;
        prev_cs   = bus.o_cs;
        prev_mosi = bus.o_mosi;
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int t;
        t = 0;
        while (!bus.o_ready && t < 500) begin
            step();
            t++;
        end
        if (!bus.o_ready) check(name, 32'd0, 32'd1);
    endtask

    task automatic send(input logic [7:0] d);
        wait_ready("send_ready_timeout");
        bus.i_data  = d;
        bus.i_valid = 1'b1;
        step();
        bus.i_valid = 1'b0;
        bus.i_data  = ~d;
    endtask

    // ---------------- stimulus ----------------
    vec_t vecs[6];

    initial begin
        int n;
        int n2;
        int rises;
        int base;
        logic ps;

        vecs[0] = '{8'hA5, 8'b1010_0101, 8'hA5};
        vecs[1] = '{8'h5A, 8'b0101_1010, 8'h5A};
        vecs[2] = '{8'h81, 8'b1000_0001, 8'h81};
        vecs[3] = '{8'hFF, 8'b1111_1111, 8'hFF};
        vecs[4] = '{8'h00, 8'b0000_0000, 8'h00};
        vecs[5] = '{8'h3C, 8'b0011_1100, 8'h3C};

        rst         = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_data  = 8'h00;

        // Reset values with no clock edge in between.
        #1 rst = 1'b1;
        #1;
        check("rst_cs", bus.o_cs, 1);
        check("rst_sck", bus.o_sck, 0);
        check("rst_mosi", bus.o_mosi, 0);
        check("rst_ready", bus.o_ready, 1);
        check("rst_done", bus.o_done, 0);
        check("rst_rx", bus.o_rx_data, 0);
        check("rst_state", dbg_state, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        step();

        // Table-driven single frames.
        for (int i = 0; i < 6; i++) begin
            push_exp(vecs[i].exp_bits, vecs[i].exp_rx);
            send(vecs[i].data);
            wait_ready("vec_ready_timeout");
            check("rx_hold", bus.o_rx_data, rx_expect(vecs[i].exp_rx));
        end

        // Single-frame timing for 0xA5: measured in cycles from T+1.
        push_exp(8'b1010_0101, 8'hA5);
        send(8'hA5);
        check("t1_cs_low", bus.o_cs, 0);
        check("t1_sck_low", bus.o_sck, 0);
        check("t1_mosi_b7", bus.o_mosi, 1);
        check("t1_ready_low", bus.o_ready, 0);
        n = 0;
        while (!bus.o_sck && n < 100) begin step(); n++; end
        check("first_rise_delay", n, CLK_DIV);
        n2 = n;
        while (!bus.o_done && n2 < 200) begin step(); n2++; end
        check("done_delay", n2, CS_LOW_LEN);
        check("cs_high_at_done", bus.o_cs, 1);
        n = 0;
        while (!bus.o_ready && n < 100) begin
            step();
            n++;
            if (n == 1) check("done_one_cycle", bus.o_done, 0);
        end
        check("ready_lag", n, READY_LAG);

        // Back-to-back frames with i_valid held high.
        push_exp(8'b0011_1100, 8'h3C);
        push_exp(8'b1100_0011, 8'hC3);
        bus.i_data  = 8'h3C;
        bus.i_valid = 1'b1;
        n = 0;
        while (bus.o_cs && n < 100) begin step(); n++; end
        bus.i_data = 8'hC3;
        n = 0;
        while (!bus.o_cs && n < 200) begin step(); n++; end
        n = 0;
        while (bus.o_cs && n < 100) begin step(); n++; end
        bus.i_valid = 1'b0;
        bus.i_data  = 8'h00;
        wait_ready("b2b_ready_timeout");
        step();
        check("b2b_gap", last_gap, GAP_B2B);

        // A request made during the HIGH phase is dropped.
        base = done_cnt;
        push_exp(8'b0000_0000, 8'h00);
        send(8'h00);
        n = 0;
        while (!bus.o_sck && n < 100) begin step(); n++; end
        bus.i_data  = 8'hFF;
        bus.i_valid = 1'b1;
        step();
        bus.i_valid = 1'b0;
        wait_ready("busy_ready_timeout");
        repeat (60) step();
        check("busy_one_done", done_cnt - base, 1);
        check("busy_idle_cs", bus.o_cs, 1);
        check("busy_queue_empty", exp_q.size(), 0);

        // Reset after the 3rd SCK rise: the frame is discarded.
        base = done_cnt;
        send(8'hEE);
        rises = 0;
        n = 0;
        ps = bus.o_sck;
        while (rises < 3 && n < 200) begin
            step();
            n++;
            if (bus.o_sck && !ps) rises++;
            ps = bus.o_sck;
        end
        step();
        check("pre_rst_sck_high", bus.o_sck, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_cs", bus.o_cs, 1);
        check("mid_rst_sck", bus.o_sck, 0);
        check("mid_rst_mosi", bus.o_mosi, 0);
        check("mid_rst_ready", bus.o_ready, 1);
        check("mid_rst_done", bus.o_done, 0);
        check("mid_rst_rx", bus.o_rx_data, 0);
        repeat (2) step();
        rst = 1'b0;
        step();
        check("post_rst_ready", bus.o_ready, 1);
        check("post_rst_state", dbg_state, 0);
        repeat (40) step();
        check("mid_rst_no_done", done_cnt - base, 0);

        push_exp(8'b1000_0001, 8'h81);
        send(8'h81);
        wait_ready("post_rst_frame_timeout");
        check("post_rst_frame_done", done_cnt - base, 1);

        repeat (5) step();
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
